// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the control unit:
// opcode field values, the NOP word, fetch FSM encodings and target helpers.
package instr_fetch_unit_pkg;

  // Opcode field values (instr[31:26]) decoded by the control unit
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  // R-type sll $0,$0,0 : the canonical do-nothing word
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Fetch FSM encodings, kept as plain constants so older tools can share them
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH   = 2'd0;
  localparam fetch_state_t ST_HOLD    = 2'd1;
  localparam fetch_state_t ST_DISCARD = 2'd2;

  // Branch target: PC+4 of the branch plus the sign-extended word offset
  function automatic logic [31:0] calcBranchTarget(input logic [31:0] pc4,
                                                   input logic [15:0] imm16);
    return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  // Jump target: top nibble of PC+4 spliced onto the 26-bit word index
  function automatic logic [31:0] calcJumpTarget(input logic [31:0] pc4,
                                                 input logic [25:0] idx26);
    return {pc4[31:28], idx26, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_target_calc.sv
// Redirect target calculation: branch and jump targets plus the priority
// mux between them. Purely combinational.
module pc_target_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic [31:0] i_pc4,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_idx26,
  output logic        o_redirect,
  output logic [31:0] o_target
);

  // Jump wins when both flags are up; either flag counts as a redirect
  always_comb begin
    o_redirect = i_branch | i_jump;
    if (i_jump) begin
      o_target = calcJumpTarget(i_pc4, i_idx26);
    end else begin
      o_target = calcBranchTarget(i_pc4, i_imm16);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks req/ack to instruction memory,
// presents fetched words through the IF/ID register, parks a word in a skid
// register when downstream is stalled, and drops wrong-path reads after a
// branch/jump redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redir_branch,
  input  logic        redir_jump,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] redir_imm16,
  input  logic [25:0] redir_idx26,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pcPlus4;
  logic         r_valid;
  logic [31:0]  r_skid;
  logic [31:0]  r_skidPc4;
  logic [31:0]  r_discardAddr;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_slotFree;
  logic [31:0]  w_pcNext4;

  pc_target_calc targetCalc (
    .i_branch   (redir_branch),
    .i_jump     (redir_jump),
    .i_pc4      (redir_pc4),
    .i_imm16    (redir_imm16),
    .i_idx26    (redir_idx26),
    .o_redirect (w_redirect),
    .o_target   (w_target)
  );

  // Memory interface and IF/ID outputs; a read in DISCARD keeps the old address
  always_comb begin
    w_slotFree  = !r_valid || !stall;
    w_pcNext4   = r_pc + 32'd4;
    imem_req    = nrst && (r_state != ST_HOLD);
    imem_addr   = (r_state == ST_DISCARD) ? r_discardAddr : r_pc;
    instr       = r_instr;
    opcode      = r_instr[31:26];
    pc_plus4    = r_pcPlus4;
    instr_valid = r_valid;
  end

  // Fetch FSM with PC, IF/ID and skid registers; redirects override everything
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_pcPlus4     <= 32'd0;
      r_valid       <= 1'b0;
      r_skid        <= NOP_INSTR;
      r_skidPc4     <= 32'd0;
      r_discardAddr <= RESET_PC;
    end else if (w_redirect) begin
      r_pc      <= w_target;
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_skid    <= NOP_INSTR;
      r_skidPc4 <= 32'd0;
      case (r_state)
        ST_FETCH: begin
          if (!imem_ack) begin
            r_discardAddr <= r_pc;
            r_state       <= ST_DISCARD;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DISCARD: r_state <= ST_DISCARD;
        default:    r_state <= ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            r_pc <= w_pcNext4;
            if (w_slotFree) begin
              r_instr   <= imem_rdata;
              r_pcPlus4 <= w_pcNext4;
              r_valid   <= 1'b1;
            end else begin
              r_skid    <= imem_rdata;
              r_skidPc4 <= w_pcNext4;
              r_state   <= ST_HOLD;
            end
          end else if (w_slotFree) begin
            r_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_slotFree) begin
            r_instr   <= r_skid;
            r_pcPlus4 <= r_skidPc4;
            r_valid   <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (imem_ack) begin
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule
